// File: rtl/plc_seq_pkg.sv
// Shared definitions for the PLC program-counter sequencer.
// Holds the opcode map, the execute-class opcode range, the sequencer
// state encoding and the opcode field width. No ports.
package plc_seq_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_EXEC_LO = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_EXEC_HI = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_JMP     = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_JMPC    = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_CALL    = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_RET     = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_WAIT    = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT    = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack for CALL/RET.
// Ports: clk, rst (async, active-high), push/push_data write entry [sp]
// then sp++; pop reads entry [sp-1] (pop_data, combinational) then sp--.
// full/empty flags, sp exposed for observation. A push while full or a
// pop while empty leaves the stack untouched.
module pc_return_stack
  import plc_seq_pkg::*;
#(
  parameter int CounterBits = 6,
  parameter int StackDepth  = 4,
  localparam int SpW        = $clog2(StackDepth + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [CounterBits-1:0] push_data,
  output logic [CounterBits-1:0] pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [SpW-1:0]         sp
);

  localparam int IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  logic [CounterBits-1:0] mem [StackDepth];
  logic [IdxW-1:0]        wr_idx;
  logic [IdxW-1:0]        rd_idx;

  assign wr_idx   = IdxW'(sp);
  assign rd_idx   = IdxW'(sp - 1'b1);
  assign full     = (sp == SpW'(StackDepth));
  assign empty    = (sp == '0);
  // Guard the read so an empty stack never indexes past the array.
  assign pop_data = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < StackDepth; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer_ctrl.sv
// Decode/control stage behind the PLC program counter.
// Decodes the program-memory word for the current PC and steers the
// counter (PC_SetJmp / PC_SetStop / PC_JMPAddr, combinational), runs
// JMP/JMPC/CALL/RET/WAIT/HALT flow control and forwards execute-class
// words (opcodes 0x1-0x9) registered to the execute stage.
// Ports: CLK, CPU_SetReset (async, active-high), PC_Counter, Instr_In,
// Cond_Flag, CPU_Run (sampled only in HALT), PC_JMPAddr, PC_SetJmp,
// PC_SetStop, Exec_Instr, Exec_Valid, Stack_Err (sticky), plus the
// observation outputs Dbg_State (FSM state) and Dbg_Sp (stack pointer).
// Exec_Valid/Exec_Instr: a one-way valid with no back-pressure; the word
// is present for exactly the one cycle Exec_Valid is high.
// Build option: define PC_CALLSTACK_EN to include the return stack;
// without it CALL/RET are illegal ops (PC advances, Stack_Err set).
module pc_sequencer_ctrl
  import plc_seq_pkg::*;
#(
  parameter int CounterBits = 6,
  parameter int InstrBits   = 16,
  parameter int StackDepth  = 4,
  localparam int SpW        = $clog2(StackDepth + 1)
) (
  input  logic                   CLK,
  input  logic                   CPU_SetReset,
  input  logic [CounterBits-1:0] PC_Counter,
  input  logic [InstrBits-1:0]   Instr_In,
  input  logic                   Cond_Flag,
  input  logic                   CPU_Run,
  output logic [CounterBits-1:0] PC_JMPAddr,
  output logic                   PC_SetJmp,
  output logic                   PC_SetStop,
  output logic [InstrBits-1:0]   Exec_Instr,
  output logic                   Exec_Valid,
  output logic                   Stack_Err,
  output logic [1:0]             Dbg_State,
  output logic [SpW-1:0]         Dbg_Sp
);

  seq_state_e             state, next_state;
  logic [CounterBits-1:0] cnt, next_cnt;
  logic [OPCODE_W-1:0]    opcode;
  logic [CounterBits-1:0] operand;
  logic                   exec_load;
  logic                   err_set;

  assign opcode    = Instr_In[InstrBits-1 -: OPCODE_W];
  assign operand   = Instr_In[CounterBits-1:0];
  assign Dbg_State = state;

`ifdef PC_CALLSTACK_EN
  logic                   stk_push, stk_pop, stk_full, stk_empty;
  logic [CounterBits-1:0] stk_top, ret_addr;

  // Return address wraps naturally at 2^CounterBits.
  assign ret_addr = PC_Counter + 1'b1;

  pc_return_stack #(
    .CounterBits (CounterBits),
    .StackDepth  (StackDepth)
  ) u_stack (
    .clk       (CLK),
    .rst       (CPU_SetReset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ret_addr),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .sp        (Dbg_Sp)
  );
`else
  logic unused_pc;
  assign unused_pc = ^PC_Counter;
  assign Dbg_Sp    = '0;
`endif

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    PC_SetJmp  = 1'b0;
    PC_SetStop = 1'b0;
    PC_JMPAddr = '0;
    exec_load  = 1'b0;
    err_set    = 1'b0;
`ifdef PC_CALLSTACK_EN
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if ((opcode >= OP_EXEC_LO) && (opcode <= OP_EXEC_HI)) begin
          exec_load = 1'b1;
        end else begin
          case (opcode)
            OP_JMP: begin
              PC_SetJmp  = 1'b1;
              PC_JMPAddr = operand;
            end
            OP_JMPC: begin
              if (Cond_Flag) begin
                PC_SetJmp  = 1'b1;
                PC_JMPAddr = operand;
              end
            end
            OP_CALL: begin
`ifdef PC_CALLSTACK_EN
              if (!stk_full) begin
                stk_push   = 1'b1;
                PC_SetJmp  = 1'b1;
                PC_JMPAddr = operand;
              end else begin
                err_set = 1'b1;
              end
`else
              err_set = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_CALLSTACK_EN
              if (!stk_empty) begin
                stk_pop    = 1'b1;
                PC_SetJmp  = 1'b1;
                PC_JMPAddr = stk_top;
              end else begin
                err_set = 1'b1;
              end
`else
              err_set = 1'b1;
`endif
            end
            OP_WAIT: begin
              // The decode cycle is the first held edge, so N-1 remain.
              if (operand != '0) begin
                PC_SetStop = 1'b1;
                next_cnt   = operand - 1'b1;
                next_state = ST_WAIT;
              end
            end
            OP_HALT: begin
              PC_SetStop = 1'b1;
              next_state = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          PC_SetStop = 1'b1;
          next_cnt   = cnt - 1'b1;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_HALT: begin
        if (CPU_Run) next_state = ST_RUN;
        else         PC_SetStop = 1'b1;
      end
      default: next_state = ST_RUN;
    endcase
    // Reset forces the counter controls quiet even though state reads RUN.
    if (CPU_SetReset) begin
      PC_SetJmp  = 1'b0;
      PC_SetStop = 1'b0;
      PC_JMPAddr = '0;
`ifdef PC_CALLSTACK_EN
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge CPU_SetReset) begin
    if (CPU_SetReset) begin
      state      <= ST_RUN;
      cnt        <= '0;
      Exec_Valid <= 1'b0;
      Exec_Instr <= '0;
      Stack_Err  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      Exec_Valid <= exec_load;
      if (exec_load) Exec_Instr <= Instr_In;
      Stack_Err  <= Stack_Err | err_set;
    end
  end

endmodule

// File: tb/tb_pc_sequencer_ctrl.sv
// Directed bench for pc_sequencer_ctrl. Inputs change 1 time unit after
// the rising edge; combinational outputs are checked once settled and
// registered outputs 1 time unit after the edge.
module tb_pc_sequencer_ctrl;
  import plc_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        CPU_SetReset;
  logic [5:0]  PC_Counter;
  logic [15:0] Instr_In;
  logic        Cond_Flag;
  logic        CPU_Run;
  logic [5:0]  PC_JMPAddr;
  logic        PC_SetJmp;
  logic        PC_SetStop;
  logic [15:0] Exec_Instr;
  logic        Exec_Valid;
  logic        Stack_Err;
  logic [1:0]  Dbg_State;
  logic [2:0]  Dbg_Sp;

  int checks = 0;
  int errors = 0;

  pc_sequencer_ctrl #(.CounterBits(6), .InstrBits(16), .StackDepth(4)) dut (
    .CLK          (CLK),
    .CPU_SetReset (CPU_SetReset),
    .PC_Counter   (PC_Counter),
    .Instr_In     (Instr_In),
    .Cond_Flag    (Cond_Flag),
    .CPU_Run      (CPU_Run),
    .PC_JMPAddr   (PC_JMPAddr),
    .PC_SetJmp    (PC_SetJmp),
    .PC_SetStop   (PC_SetStop),
    .Exec_Instr   (Exec_Instr),
    .Exec_Valid   (Exec_Valid),
    .Stack_Err    (Stack_Err),
    .Dbg_State    (Dbg_State),
    .Dbg_Sp       (Dbg_Sp)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    CPU_SetReset = 1'b1;
    Instr_In     = 16'h0000;
    #2;
    CPU_SetReset = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    CPU_SetReset = 1'b1;
    PC_Counter   = 6'd0;
    Instr_In     = 16'hA02A;
    Cond_Flag    = 1'b0;
    CPU_Run      = 1'b0;
    #2;
    checks++; if (PC_SetJmp !== 1'b0) begin errors++; $display("FAIL rst_setjmp actual=%0b required=0", PC_SetJmp); end
    checks++; if (PC_JMPAddr !== 6'h00) begin errors++; $display("FAIL rst_jmpaddr actual=%0h required=00", PC_JMPAddr); end
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL rst_setstop actual=%0b required=0", PC_SetStop); end
    checks++; if (Exec_Valid !== 1'b0) begin errors++; $display("FAIL rst_exec_valid actual=%0b required=0", Exec_Valid); end
    checks++; if (Exec_Instr !== 16'h0000) begin errors++; $display("FAIL rst_exec_instr actual=%0h required=0000", Exec_Instr); end
    checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL rst_stack_err actual=%0b required=0", Stack_Err); end
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL rst_state actual=%0d required=%0d", Dbg_State, ST_RUN); end
    // An execute word presented across an edge during reset must not load.
    Instr_In = 16'h3ABC;
    tick;
    checks++; if (Exec_Valid !== 1'b0) begin errors++; $display("FAIL rst_exec_hold actual=%0b required=0", Exec_Valid); end
    Instr_In = 16'h0000;
    CPU_SetReset = 1'b0;
    tick;
  endtask

  task automatic test_jmp;
    PC_Counter = 6'h05; Instr_In = 16'hA02A; #1;
    checks++; if (PC_SetJmp !== 1'b1) begin errors++; $display("FAIL jmp_set actual=%0b required=1", PC_SetJmp); end
    checks++; if (PC_JMPAddr !== 6'h2A) begin errors++; $display("FAIL jmp_addr actual=%0h required=2a", PC_JMPAddr); end
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL jmp_stop actual=%0b required=0", PC_SetStop); end
    tick;
    PC_Counter = 6'h2A; Instr_In = 16'hB010; Cond_Flag = 1'b0; #1;
    checks++; if (PC_SetJmp !== 1'b0) begin errors++; $display("FAIL jmpc0_set actual=%0b required=0", PC_SetJmp); end
    checks++; if (PC_JMPAddr !== 6'h00) begin errors++; $display("FAIL jmpc0_addr actual=%0h required=00", PC_JMPAddr); end
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL jmpc0_stop actual=%0b required=0", PC_SetStop); end
    tick;
    PC_Counter = 6'h2B; Cond_Flag = 1'b1; #1;
    checks++; if (PC_SetJmp !== 1'b1) begin errors++; $display("FAIL jmpc1_set actual=%0b required=1", PC_SetJmp); end
    checks++; if (PC_JMPAddr !== 6'h10) begin errors++; $display("FAIL jmpc1_addr actual=%0h required=10", PC_JMPAddr); end
    tick;
    Cond_Flag = 1'b0;
  endtask

  task automatic test_exec;
    logic [15:0] words [6];
    logic        valid [6];
    words = '{16'h3ABC, 16'h1FFF, 16'h9123, 16'h0000, 16'hE000, 16'hB010};
    valid = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      PC_Counter = 6'(i + 8);
      Instr_In   = words[i];
      #1;
      checks++; if ({PC_SetJmp, PC_SetStop} !== 2'b00) begin errors++; $display("FAIL exec_ctrl[%0d] actual=%0b required=00", i, {PC_SetJmp, PC_SetStop}); end
      tick;
      Instr_In = 16'h0000;
      checks++; if (Exec_Valid !== valid[i]) begin errors++; $display("FAIL exec_valid[%0d] actual=%0b required=%0b", i, Exec_Valid, valid[i]); end
      if (valid[i]) begin
        checks++; if (Exec_Instr !== words[i]) begin errors++; $display("FAIL exec_instr[%0d] actual=%0h required=%0h", i, Exec_Instr, words[i]); end
      end
    end
    tick;
    checks++; if (Exec_Valid !== 1'b0) begin errors++; $display("FAIL exec_drop actual=%0b required=0", Exec_Valid); end
  endtask

  task automatic test_wait;
    int held;
    int bad_jmp;
    held = 0; bad_jmp = 0;
    PC_Counter = 6'h10; Instr_In = 16'hE003; #1;
    for (int i = 0; i < 10; i++) begin
      if (PC_SetJmp) bad_jmp++;
      if (!PC_SetStop) break;
      held++;
      tick;
      Instr_In = 16'hA011;   // must be ignored while waiting
      #1;
    end
    checks++; if (held !== 3) begin errors++; $display("FAIL wait3_held actual=%0d required=3", held); end
    checks++; if (bad_jmp !== 0) begin errors++; $display("FAIL wait3_ignore actual=%0d required=0", bad_jmp); end
    checks++; if (Dbg_State !== ST_WAIT) begin errors++; $display("FAIL wait3_last actual=%0d required=%0d", Dbg_State, ST_WAIT); end
    Instr_In = 16'h0000;
    tick;
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL wait3_exit actual=%0d required=%0d", Dbg_State, ST_RUN); end
    // WAIT 0 is a plain NOP
    Instr_In = 16'hE000; #1;
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL wait0_stop actual=%0b required=0", PC_SetStop); end
    tick;
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL wait0_state actual=%0d required=%0d", Dbg_State, ST_RUN); end
  endtask

  task automatic test_halt;
    int held;
    held = 0;
    PC_Counter = 6'h20; Instr_In = 16'hF000; CPU_Run = 1'b1; #1;
    checks++; if (PC_SetStop !== 1'b1) begin errors++; $display("FAIL halt_dec_stop actual=%0b required=1", PC_SetStop); end
    tick;
    CPU_Run = 1'b0; Instr_In = 16'hA011; #1;
    checks++; if (Dbg_State !== ST_HALT) begin errors++; $display("FAIL halt_enter actual=%0d required=%0d", Dbg_State, ST_HALT); end
    for (int i = 0; i < 10; i++) begin
      if (PC_SetStop && !PC_SetJmp) held++;
      tick;
    end
    checks++; if (held !== 10) begin errors++; $display("FAIL halt_held actual=%0d required=10", held); end
    CPU_Run = 1'b1; #1;
    checks++; if ({PC_SetStop, PC_SetJmp} !== 2'b00) begin errors++; $display("FAIL halt_resume actual=%0b required=00", {PC_SetStop, PC_SetJmp}); end
    tick;
    CPU_Run = 1'b0; PC_Counter = 6'h21; Instr_In = 16'h0000; #1;
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL halt_run actual=%0d required=%0d", Dbg_State, ST_RUN); end
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL halt_run_stop actual=%0b required=0", PC_SetStop); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
`ifdef PC_CALLSTACK_EN
    PC_Counter = 6'h01; Instr_In = 16'hC030; #1;
    tick;
    checks++; if (Dbg_Sp !== 3'd1) begin errors++; $display("FAIL rmw_pre_sp actual=%0d required=1", Dbg_Sp); end
`endif
    PC_Counter = 6'h30; Instr_In = 16'h3ABC; #1;
    tick;
    Instr_In = 16'hE005; #1;
    checks++; if (PC_SetStop !== 1'b1) begin errors++; $display("FAIL rmw_dec_stop actual=%0b required=1", PC_SetStop); end
    tick;
    tick;
    checks++; if (Dbg_State !== ST_WAIT) begin errors++; $display("FAIL rmw_in_wait actual=%0d required=%0d", Dbg_State, ST_WAIT); end
    #2 CPU_SetReset = 1'b1;
    #1;
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL rmw_state actual=%0d required=%0d", Dbg_State, ST_RUN); end
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL rmw_stop actual=%0b required=0", PC_SetStop); end
    checks++; if (Exec_Valid !== 1'b0) begin errors++; $display("FAIL rmw_valid actual=%0b required=0", Exec_Valid); end
    checks++; if (Dbg_Sp !== 3'd0) begin errors++; $display("FAIL rmw_sp actual=%0d required=0", Dbg_Sp); end
    Instr_In = 16'h0000;
    #1 CPU_SetReset = 1'b0;
    #1;
    checks++; if (PC_SetStop !== 1'b0) begin errors++; $display("FAIL rmw_after_stop actual=%0b required=0", PC_SetStop); end
    tick;
    checks++; if (Dbg_State !== ST_RUN) begin errors++; $display("FAIL rmw_after_state actual=%0d required=%0d", Dbg_State, ST_RUN); end
  endtask

`ifdef PC_CALLSTACK_EN
  task automatic test_call_ret;
    do_reset;
    PC_Counter = 6'h3F; Instr_In = 16'hC005; #1;
    checks++; if ({PC_SetJmp, PC_JMPAddr} !== {1'b1, 6'h05}) begin errors++; $display("FAIL call_jmp actual=%0b/%0h required=1/05", PC_SetJmp, PC_JMPAddr); end
    tick;
    checks++; if (Dbg_Sp !== 3'd1) begin errors++; $display("FAIL call_sp actual=%0d required=1", Dbg_Sp); end
    PC_Counter = 6'h05; Instr_In = 16'hD000; #1;
    checks++; if ({PC_SetJmp, PC_JMPAddr} !== {1'b1, 6'h00}) begin errors++; $display("FAIL ret_wrap actual=%0b/%0h required=1/00", PC_SetJmp, PC_JMPAddr); end
    tick;
    checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL ret_err_clear actual=%0b required=0", Stack_Err); end
    PC_Counter = 6'h00; #1;
    checks++; if ({PC_SetJmp, PC_SetStop} !== 2'b00) begin errors++; $display("FAIL ret_empty_ctrl actual=%0b required=00", {PC_SetJmp, PC_SetStop}); end
    tick;
    checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL ret_empty_err actual=%0b required=1", Stack_Err); end
    Instr_In = 16'h0000;
    tick;
    checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL err_sticky actual=%0b required=1", Stack_Err); end
  endtask

  task automatic test_overflow;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      PC_Counter = 6'(i);
      Instr_In   = {4'hC, 12'(16 + i)};
      #1;
      checks++; if ({PC_SetJmp, PC_JMPAddr} !== {1'b1, 6'(16 + i)}) begin errors++; $display("FAIL ovf_call[%0d] actual=%0b/%0h required=1/%0h", i, PC_SetJmp, PC_JMPAddr, 16 + i); end
      tick;
    end
    PC_Counter = 6'h04; Instr_In = 16'hC020; #1;
    checks++; if ({PC_SetJmp, PC_SetStop} !== 2'b00) begin errors++; $display("FAIL ovf_5th_ctrl actual=%0b required=00", {PC_SetJmp, PC_SetStop}); end
    tick;
    checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL ovf_err actual=%0b required=1", Stack_Err); end
    checks++; if (Dbg_Sp !== 3'd4) begin errors++; $display("FAIL ovf_sp actual=%0d required=4", Dbg_Sp); end
    PC_Counter = 6'h13; Instr_In = 16'hD000; #1;
    checks++; if ({PC_SetJmp, PC_JMPAddr} !== {1'b1, 6'h04}) begin errors++; $display("FAIL ovf_ret actual=%0b/%0h required=1/04", PC_SetJmp, PC_JMPAddr); end
    tick;
    checks++; if (Dbg_Sp !== 3'd3) begin errors++; $display("FAIL ovf_ret_sp actual=%0d required=3", Dbg_Sp); end
    Instr_In = 16'h0000;
  endtask
`else
  task automatic test_illegal_stack_ops;
    do_reset;
    PC_Counter = 6'h03; Instr_In = 16'hC005; #1;
    checks++; if ({PC_SetJmp, PC_SetStop} !== 2'b00) begin errors++; $display("FAIL nocall_ctrl actual=%0b required=00", {PC_SetJmp, PC_SetStop}); end
    tick;
    checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL nocall_err actual=%0b required=1", Stack_Err); end
    do_reset;
    checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL noret_pre_err actual=%0b required=0", Stack_Err); end
    PC_Counter = 6'h04; Instr_In = 16'hD000; #1;
    checks++; if (PC_SetJmp !== 1'b0) begin errors++; $display("FAIL noret_jmp actual=%0b required=0", PC_SetJmp); end
    tick;
    checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL noret_err actual=%0b required=1", Stack_Err); end
    Instr_In = 16'h0000;
    tick;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_jmp;
    test_exec;
    test_wait;
    test_halt;
    test_reset_mid_wait;
`ifdef PC_CALLSTACK_EN
    test_call_ret;
    test_overflow;
`else
    test_illegal_stack_ops;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
